// File: rtl/ctrl_pkg.sv
// Shared constants for the control sequencer and the datapath: state codes,
// opcodes, immediate-mode pattern and ALU_OP codes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_START0    = 3'd0,
        ST_START1    = 3'd1,
        ST_FETCH     = 3'd2,
        ST_DECODE    = 3'd3,
        ST_EXECUTE   = 3'd4,
        ST_MEM       = 3'd5,
        ST_WRITEBACK = 3'd6,
        ST_HALT      = 3'd7
    } state_t;

    localparam int OP_NOOP = 0;
    localparam int OP_LOD  = 1;
    localparam int OP_STR  = 2;
    localparam int OP_BRA  = 4;
    localparam int OP_BRR  = 5;
    localparam int OP_BNE  = 6;
    localparam int OP_ALU  = 8;

    localparam int ALU_REG = 0;
    localparam int ALU_IMM = 1;
    localparam int ALU_BR  = 2;

    // HLT is all-ones at whatever opcode width is in use
    function automatic logic [31:0] op_hlt(input int opw);
        return (32'd1 << opw) - 32'd1;
    endfunction

    // Immediate mode: MSB of MM set, every other bit clear
    function automatic logic [31:0] imm_mode(input int mmw);
        return 32'd1 << (mmw - 1);
    endfunction

endpackage

// File: rtl/ctrl_seq_if.sv
// Instruction/status inputs and control outputs between sequencer (master)
// and datapath (slave).
interface ctrl_seq_if #(
    parameter int OPW  = 4,
    parameter int MMW  = 4,
    parameter int ALUW = 2
);
    logic [OPW-1:0]  OPCODE;
    logic [MMW-1:0]  MM;
    logic [MMW-1:0]  STAT;
    logic            MEM_RDY;
    logic            PC_RST;
    logic            PC_WRITE;
    logic            PC_SEL;
    logic            BR_SEL;
    logic            RD_SEL;
    logic            MM_SEL;
    logic            WB_SEL;
    logic            RF_WE;
    logic            DM_WE;
    logic [ALUW-1:0] ALU_OP;
    logic            HALTED;
    logic [2:0]      STATE;

    modport master (
        input  OPCODE, MM, STAT, MEM_RDY,
        output PC_RST, PC_WRITE, PC_SEL, BR_SEL, RD_SEL, MM_SEL, WB_SEL,
               RF_WE, DM_WE, ALU_OP, HALTED, STATE
    );

    modport slave (
        output OPCODE, MM, STAT, MEM_RDY,
        input  PC_RST, PC_WRITE, PC_SEL, BR_SEL, RD_SEL, MM_SEL, WB_SEL,
               RF_WE, DM_WE, ALU_OP, HALTED, STATE
    );
endinterface

// File: rtl/ctrl_br_eval.sv
// Branch condition evaluation: taken flag and branch-target source select.
module ctrl_br_eval
    import ctrl_pkg::*;
#(
    parameter int OPW = 4,
    parameter int MMW = 4
) (
    input  logic [MMW-1:0] MM,
    input  logic [MMW-1:0] STAT,
    input  logic [OPW-1:0] OPCODE,
    output logic           taken,
    output logic           br_sel
);
    logic hit, is_bra, is_brr, is_bne;

    assign hit    = |(MM & STAT);
    assign is_bra = (OPCODE == OPW'(OP_BRA));
    assign is_brr = (OPCODE == OPW'(OP_BRR));
    assign is_bne = (OPCODE == OPW'(OP_BNE));

    assign taken  = ((is_bra | is_brr) & hit) | (is_bne & ~hit);
    assign br_sel = is_bra | is_bne;
endmodule

// File: rtl/ctrl_seq.sv
// Multi-cycle control sequencer. Define CTRL_SEQ_STALL_EN to hold MEM until
// MEM_RDY is high; otherwise MEM lasts one cycle and MEM_RDY is ignored.
module ctrl_seq
    import ctrl_pkg::*;
#(
    parameter int OPW  = 4,
    parameter int MMW  = 4,
    parameter int ALUW = 2
) (
    input logic        CLK,
    input logic        RST_F,
    ctrl_seq_if.master bus
);
    localparam logic [MMW-1:0] MM_IMM = MMW'(imm_mode(MMW));
    localparam logic [OPW-1:0] OP_HLT = OPW'(op_hlt(OPW));

    state_t state, state_nx;

    logic is_lod, is_str, is_alu, is_hlt, is_br, imm;
    logic taken, br_sel;

    assign is_lod = (bus.OPCODE == OPW'(OP_LOD));
    assign is_str = (bus.OPCODE == OPW'(OP_STR));
    assign is_alu = (bus.OPCODE == OPW'(OP_ALU));
    assign is_hlt = (bus.OPCODE == OP_HLT);
    assign is_br  = (bus.OPCODE == OPW'(OP_BRA)) | (bus.OPCODE == OPW'(OP_BRR)) |
                    (bus.OPCODE == OPW'(OP_BNE));
    assign imm    = (bus.MM == MM_IMM);

    ctrl_br_eval #(.OPW(OPW), .MMW(MMW)) u_br_eval (
        .MM     (bus.MM),
        .STAT   (bus.STAT),
        .OPCODE (bus.OPCODE),
        .taken  (taken),
        .br_sel (br_sel)
    );

`ifndef CTRL_SEQ_STALL_EN
    logic unused_mem_rdy;
    assign unused_mem_rdy = bus.MEM_RDY;
`endif

    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) state <= ST_START0;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_START0:    state_nx = ST_START1;
            ST_START1:    state_nx = ST_FETCH;
            ST_FETCH:     state_nx = ST_DECODE;
            ST_DECODE:    state_nx = is_hlt ? ST_HALT : ST_EXECUTE;
            ST_EXECUTE: begin
                if (is_lod | is_str) state_nx = ST_MEM;
                else if (is_alu)     state_nx = ST_WRITEBACK;
                else                 state_nx = ST_FETCH;
            end
            ST_MEM: begin
`ifdef CTRL_SEQ_STALL_EN
                if (!bus.MEM_RDY)    state_nx = ST_MEM;
                else
`endif
                state_nx = is_lod ? ST_WRITEBACK : ST_FETCH;
            end
            ST_WRITEBACK: state_nx = ST_FETCH;
            ST_HALT:      state_nx = ST_HALT;
            default:      state_nx = ST_START0;
        endcase
    end

    logic            pc_rst, pc_write, pc_sel, br_sel_o, rd_sel, mm_sel;
    logic            wb_sel, rf_we, dm_we;
    logic [ALUW-1:0] alu_op, alu_code;
    logic            in_exe_wb, in_dec_wb;

    // ALU source: immediate ALU and register-mode LOD/STR share code 1
    always_comb begin
        alu_code = ALUW'(ALU_REG);
        if (is_alu)              alu_code = imm ? ALUW'(ALU_IMM) : ALUW'(ALU_REG);
        else if (is_lod | is_str) alu_code = imm ? ALUW'(ALU_REG) : ALUW'(ALU_IMM);
        else if (is_br)          alu_code = ALUW'(ALU_BR);
    end

    assign in_exe_wb = (state == ST_EXECUTE) | (state == ST_MEM) | (state == ST_WRITEBACK);
    assign in_dec_wb = in_exe_wb | (state == ST_DECODE);

    always_comb begin
        pc_rst   = (state == ST_START0) | (state == ST_START1);
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        br_sel_o = 1'b0;
        rd_sel   = in_dec_wb & (is_lod | (is_alu & imm));
        mm_sel   = in_exe_wb & (is_lod | is_str) & imm;
        alu_op   = in_exe_wb ? alu_code : '0;
        wb_sel   = ((state == ST_MEM) | (state == ST_WRITEBACK)) & is_lod;
        rf_we    = (state == ST_WRITEBACK) & (is_lod | is_alu);
        dm_we    = (state == ST_MEM) & is_str;
        if (state == ST_FETCH) pc_write = 1'b1;
        if (state == ST_EXECUTE) begin
            pc_write = taken;
            pc_sel   = taken;
            br_sel_o = br_sel;
        end
    end

    assign bus.PC_RST   = pc_rst;
    assign bus.PC_WRITE = pc_write;
    assign bus.PC_SEL   = pc_sel;
    assign bus.BR_SEL   = br_sel_o;
    assign bus.RD_SEL   = rd_sel;
    assign bus.MM_SEL   = mm_sel;
    assign bus.WB_SEL   = wb_sel;
    assign bus.RF_WE    = rf_we;
    assign bus.DM_WE    = dm_we;
    assign bus.ALU_OP   = alu_op;
    assign bus.HALTED   = (state == ST_HALT);
    assign bus.STATE    = state;
endmodule

// File: tb/tb_ctrl_seq.sv
// Scoreboard bench for ctrl_seq: per-instruction cycle traces from a
// phase-list reference model, checked every cycle by an independent monitor.
module tb_ctrl_seq;
    localparam int OPW = 4, MMW = 4, ALUW = 2;

    localparam int P_S0 = 0, P_S1 = 1, P_FE = 2, P_DE = 3, P_EX = 4,
                   P_ME = 5, P_WB = 6, P_HA = 7;

    logic CLK = 1'b0;
    logic RST_F = 1'b0;

    ctrl_seq_if #(.OPW(OPW), .MMW(MMW), .ALUW(ALUW)) bus ();

    ctrl_seq #(.OPW(OPW), .MMW(MMW), .ALUW(ALUW)) dut (
        .CLK   (CLK),
        .RST_F (RST_F),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [2:0] st;
        logic       halted, pc_rst, pc_write, pc_sel, br_sel, rd_sel;
        logic       mm_sel, wb_sel, rf_we, dm_we;
        logic [1:0] alu_op;
    } obs_t;

    obs_t sb_q[$];
    obs_t mon_exp;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   mon_en = 0;

    function automatic obs_t sample();
        obs_t o;
        o.st = bus.STATE;       o.halted = bus.HALTED;   o.pc_rst = bus.PC_RST;
        o.pc_write = bus.PC_WRITE; o.pc_sel = bus.PC_SEL; o.br_sel = bus.BR_SEL;
        o.rd_sel = bus.RD_SEL;  o.mm_sel = bus.MM_SEL;   o.wb_sel = bus.WB_SEL;
        o.rf_we = bus.RF_WE;    o.dm_we = bus.DM_WE;     o.alu_op = bus.ALU_OP;
        return o;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h (st=%0d) expected %h (st=%0d)",
                     name, $time, act, act.st, exp, exp.st);
        end
    endtask

    // Instruction semantics as seen at the control outputs, phase by phase
    function automatic obs_t model(input int ph, input int opc, input int mm, input int stat);
        obs_t m = '0;
        bit lod = (opc == 1), str = (opc == 2), alu = (opc == 8);
        bit bra = (opc == 4), brr = (opc == 5), bne = (opc == 6);
        bit imm = (mm == 8);
        bit hit = ((mm & stat) != 0);
        bit taken = ((bra || brr) && hit) || (bne && !hit);
        bit exwb = (ph == P_EX) || (ph == P_ME) || (ph == P_WB);
        m.st       = 3'(ph);
        m.halted   = (ph == P_HA);
        m.pc_rst   = (ph == P_S0) || (ph == P_S1);
        m.pc_write = (ph == P_FE) || ((ph == P_EX) && taken);
        m.pc_sel   = (ph == P_EX) && taken;
        m.br_sel   = (ph == P_EX) && (bra || bne);
        m.rd_sel   = (exwb || ph == P_DE) && (lod || (alu && imm));
        m.mm_sel   = exwb && (lod || str) && imm;
        m.wb_sel   = ((ph == P_ME) || (ph == P_WB)) && lod;
        m.rf_we    = (ph == P_WB) && (lod || alu);
        m.dm_we    = (ph == P_ME) && str;
        if (exwb) begin
            if (alu)              m.alu_op = imm ? 2'd1 : 2'd0;
            else if (lod || str)  m.alu_op = imm ? 2'd0 : 2'd1;
            else if (bra || brr || bne) m.alu_op = 2'd2;
        end
        return m;
    endfunction

    always @(negedge CLK) begin
        if (mon_en) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_underflow @%0t: got empty queue, required an entry", $time);
            end else begin
                mon_exp = sb_q.pop_front();
                check("cycle", sample(), mon_exp);
            end
        end
    end

    // Stall cycles only exist in the stall build
    function automatic int eff_wait(input int w);
`ifdef CTRL_SEQ_STALL_EN
        return w;
`else
        return 0 * w;
`endif
    endfunction

    task automatic do_reset();
        mon_en = 0;
        n_chk++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain @%0t: got %0d left, required 0", $time, sb_q.size());
            sb_q.delete();
        end
        RST_F = 1'b0;
        #1;
        check("rst_async", sample(), model(P_S0, 0, 0, 0));
        @(posedge CLK); #1;
        check("rst_hold", sample(), model(P_S0, 0, 0, 0));
        #1 RST_F = 1'b1;
        @(posedge CLK); #1;
        sb_q.push_back(model(P_S1, 0, 0, 0));
        mon_en = 1;
        @(posedge CLK); #1;
    endtask

    // Entered at posedge+1 of a FETCH cycle; leaves at posedge+1 of the next one
    task automatic run_instr(input int opc, input int mm, input int stat, input int w_in, input bit abort);
        int phs[$];
        int w = eff_wait(w_in);
        int mem_n = 0;
        bit memop = (opc == 1) || (opc == 2);
        phs.push_back(P_FE);
        phs.push_back(P_DE);
        if (opc == 15) begin
            repeat (20) phs.push_back(P_HA);
        end else begin
            phs.push_back(P_EX);
            if (memop) begin
                if (abort) phs.push_back(P_ME);
                else repeat (w + 1) phs.push_back(P_ME);
            end
            if (!abort && (opc == 1 || opc == 8)) phs.push_back(P_WB);
        end
        foreach (phs[i]) sb_q.push_back(model(phs[i], opc, mm, stat));
        foreach (phs[i]) begin
            if (i == 0) begin
                bus.OPCODE = OPW'($urandom);
                bus.MM     = MMW'($urandom);
                bus.STAT   = MMW'($urandom);
            end else begin
                bus.OPCODE = OPW'(opc);
                bus.MM     = MMW'(mm);
                bus.STAT   = MMW'(stat);
            end
            bus.MEM_RDY = 1'($urandom);
`ifdef CTRL_SEQ_STALL_EN
            if (phs[i] == P_ME) begin
                bus.MEM_RDY = (mem_n == w);
                mem_n++;
            end
`endif
            if (abort && phs[i] == P_ME) begin
                @(negedge CLK); #1;
                return;
            end
            @(posedge CLK); #1;
        end
        mem_n = mem_n + 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ops[11] = '{0, 1, 2, 4, 5, 6, 8, 3, 7, 9, 12};
        int opc, mm, stat, w;
        bit ab;
        bus.OPCODE = '0; bus.MM = '0; bus.STAT = '0; bus.MEM_RDY = 1'b0;
        do_reset();
        repeat (3) run_instr(0, 0, 0, 0, 0);
        run_instr(8, 8, 0, 0, 0);
        run_instr(6, 3, 4, 0, 0);
        run_instr(6, 3, 1, 0, 0);
        run_instr(1, 0, 0, 3, 0);
        run_instr(2, 8, 0, 2, 0);
        run_instr(2, 8, 0, 0, 1);
        do_reset();
        run_instr(15, 0, 0, 0, 0);
        do_reset();
        for (int n = 0; n < 300; n++) begin
            opc  = ($urandom_range(0, 99) < 2) ? 15 : ops[$urandom_range(0, 10)];
            mm   = ($urandom_range(0, 2) == 0) ? 8 : int'($urandom_range(0, 15));
            stat = $urandom_range(0, 15);
            w    = $urandom_range(0, 3);
            ab   = ((opc == 1) || (opc == 2)) && ($urandom_range(0, 99) < 4);
            run_instr(opc, mm, stat, w, ab);
            if (opc == 15 || ab) do_reset();
        end
        mon_en = 0;
        n_chk++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_final @%0t: got %0d left, required 0", $time, sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ctrl_seq.md
CTRL_SEQ -- requirements
Module: ctrl_seq

Interface
REQ-001 Parameter OPW, default 4, opcode field width.
REQ-002 Parameter MMW, default 4, mode/condition-mask field width; also width of STAT.
REQ-003 Parameter ALUW, default 2, ALU_OP width, minimum 2.
REQ-004 Port CLK  in  1  sole clock, rising edge active.
REQ-005 Port RST_F  in  1  asynchronous active-low reset.
REQ-006 Ports OPCODE in OPW and MM in MMW carry the current instruction fields; STAT in MMW carries the ALU status flags.
REQ-007 Port MEM_RDY  in  1  data-memory access complete.
REQ-008 Ports PC_RST, PC_WRITE, PC_SEL, BR_SEL, RD_SEL, MM_SEL, WB_SEL, RF_WE, DM_WE are 1-bit outputs; ALU_OP is an ALUW-bit output.
REQ-009 Port HALTED  out  1  high while the sequencer is in HALT; STATE  out  3  present-state encoding.

Function
REQ-010 States: START0, START1, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT; the state register is the only sequential element.
REQ-011 Opcodes: NOOP=0, LOD=1, STR=2, BRA=4, BRR=5, BNE=6, ALU=8, HLT=all-ones; any other value decodes as NOOP; MM immediate mode = MSB of MM set, all other MM bits zero.
REQ-012 Transitions: START0->START1->FETCH->DECODE; DECODE->HALT if HLT, else EXECUTE.
REQ-013 EXECUTE->MEM for LOD/STR, ->WRITEBACK for ALU, ->FETCH for NOOP and all branches (taken or not).
REQ-014 MEM->WRITEBACK for LOD, ->FETCH for STR; WRITEBACK->FETCH; HALT is sticky until reset.
REQ-015 Branch taken: BRA/BRR when (MM & STAT)!=0; BNE when (MM & STAT)==0.
REQ-016 Outputs are combinational from present state, OPCODE, MM, STAT; all are 0 unless stated.
REQ-017 PC_RST=1 in START0/START1; PC_WRITE=1 in FETCH (PC_SEL=0) and in EXECUTE on a taken branch (PC_SEL=1).
REQ-018 BR_SEL=1 for BRA and BNE, 0 for BRR, in EXECUTE.
REQ-019 RD_SEL=1 from DECODE through WRITEBACK for LOD or immediate-mode ALU.
REQ-020 ALU_OP from EXECUTE through WRITEBACK: 1 for immediate ALU or register-mode LOD/STR; 0 for register ALU or immediate LOD/STR; 2 for branches.
REQ-021 MM_SEL=1 from EXECUTE through WRITEBACK for immediate-mode LOD/STR.
REQ-022 DM_WE=1 in MEM for STR; WB_SEL=1 in MEM and WRITEBACK for LOD; RF_WE=1 in WRITEBACK for ALU and LOD only.
REQ-023 Latency from FETCH entry to next FETCH entry: NOOP/branch 3, ALU 4, STR 4, LOD 5 cycles, absent stalls.
REQ-024 OPCODE/MM are held stable by the datapath from DECODE until the next FETCH; changes in FETCH are legal.

Reset
REQ-025 RST_F low forces START0 immediately from any state, including mid-MEM or HALT; outputs then follow REQ-017 (PC_RST=1, others 0).
REQ-026 Release is sampled on the first rising CLK with RST_F high; START0->START1 on that edge.

Configuration
REQ-027 Macro CTRL_SEQ_STALL_EN defined: MEM holds while MEM_RDY=0, DM_WE remains asserted, exit per REQ-014 on the first cycle MEM_RDY=1.
REQ-028 Macro undefined: MEM_RDY is ignored and MEM lasts exactly one cycle.

Structure
REQ-029 Shared package ctrl_pkg holds state encodings, opcode constants, immediate-mode constant and ALU_OP codes; the datapath imports the same opcode constants.
REQ-030 One sub-module, ctrl_br_eval (MM, STAT, OPCODE -> taken, br_sel), is natural; output decode stays in ctrl_seq.

Verification
REQ-031 Reset release, OPCODE=0 -> PC_RST=1 two cycles, then FETCH with PC_WRITE=1, loop period 3 cycles.
REQ-032 OPCODE=8, MM=8 -> RD_SEL=1 from DECODE, ALU_OP=1 in EXECUTE, RF_WE=1 only in WRITEBACK, next FETCH 4 cycles after previous.
REQ-033 OPCODE=6, MM=4'b0011, STAT=4'b0100 -> taken, PC_SEL=1, BR_SEL=1, PC_WRITE=1 in EXECUTE; STAT=4'b0001 -> not taken, PC_WRITE=0.
REQ-034 OPCODE=1, MM=0 with CTRL_SEQ_STALL_EN, MEM_RDY low 3 cycles -> MEM held 4 cycles, WB_SEL=1 throughout, RF_WE=1 in WRITEBACK only.
REQ-035 OPCODE=4'hF -> HALT after DECODE, HALTED=1, no PC_WRITE for 20 cycles; RST_F pulse low -> START0, HALTED=0.
REQ-036 OPCODE=2, MM=8, RST_F asserted in MEM -> DM_WE drops immediately, STATE=START0 without waiting for CLK.
